// File: rtl/court_display_ctrl.sv
// Court renderer display sequencer: VGA scan timing plus frame-aligned court-mode commits.
// All outputs registered, decoded from next-state x/y so they line up with x_o/y_o.
module court_display_ctrl #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int BLANK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce_i,
    input  logic        mode_req_i,
    input  logic [1:0]  mode_sel_i,
    output logic        mode_ack_o,
    output logic        mode_err_o,
    output logic [1:0]  mode_o,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic        enable_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        frame_start_o,
    output logic        busy_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [3:0]  BLANK_N  = 4'(BLANK_FRAMES);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [1:0]  mode_q, mode_d, pend_q, pend_d;
    logic [3:0]  blank_q, blank_d;
    logic        ack_q, ack_d, err_q, err_d;
    logic        en_q, en_d, hs_q, hs_d, vs_q, vs_d;
    logic        fs_q, fs_d, busy_q, busy_d;
    logic        frame_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            pend_q  <= '0;
            blank_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            blank_q <= blank_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            en_q    <= en_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        mode_d    = mode_q;
        pend_d    = pend_q;
        blank_d   = blank_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        frame_end = pix_ce_i && (x_q == H_LAST) && (y_q == V_LAST);

        if (pix_ce_i) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? 11'd0 : y_q + 11'd1;
            end else begin
                x_d = x_q + 11'd1;
            end
        end

        case (state_q)
            RUN: begin
                // The requester still holds mode_req while our ack is out; don't take it twice.
                if (mode_req_i && !ack_q) begin
                    ack_d = 1'b1;
                    if (mode_sel_i == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        pend_d  = mode_sel_i;
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                if (frame_end) begin
                    mode_d  = pend_q;
                    blank_d = BLANK_N;
                    state_d = BLANK;
                end
            end
            BLANK: begin
                if (frame_end) begin
                    if (blank_q == 4'd1) begin
                        blank_d = '0;
                        state_d = RUN;
                    end else begin
                        blank_d = blank_q - 4'd1;
                    end
                end
            end
            default: state_d = RUN;
        endcase

        en_d   = (x_d < H_ACT) && (y_d < V_ACT) && (state_d != BLANK);
        hs_d   = !((x_d >= HS_START) && (x_d < HS_END));
        vs_d   = !((y_d >= VS_START) && (y_d < VS_END));
        fs_d   = frame_end;
        busy_d = (state_d != RUN);
    end

    assign mode_ack_o    = ack_q;
    assign mode_err_o    = err_q;
    assign mode_o        = mode_q;
    assign x_o           = x_q;
    assign y_o           = y_q;
    assign enable_o      = en_q;
    assign hsync_o       = hs_q;
    assign vsync_o       = vs_q;
    assign frame_start_o = fs_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_court_display_ctrl.sv
// Directed bench for court_display_ctrl on a shrunken 24x10 raster (frame = 240 pixels).
module tb_court_display_ctrl;
    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_ce_i = 1'b0;
    logic        mode_req_i = 1'b0;
    logic [1:0]  mode_sel_i = 2'd0;
    logic        mode_ack_o, mode_err_o, enable_o, hsync_o, vsync_o, frame_start_o, busy_o;
    logic [1:0]  mode_o;
    logic [10:0] x_o, y_o;

    court_display_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .BLANK_FRAMES(2)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce_i(pix_ce_i),
        .mode_req_i(mode_req_i), .mode_sel_i(mode_sel_i),
        .mode_ack_o(mode_ack_o), .mode_err_o(mode_err_o), .mode_o(mode_o),
        .x_o(x_o), .y_o(y_o), .enable_o(enable_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
        .frame_start_o(frame_start_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int mx = 0, my = 0, cyc = 0;
    int xy_err = 0, sync_err = 0, fs_err = 0;
    int en_cnt, hs_lo, vs_lo, mode_nz, busy_cnt, fs_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr();
        en_cnt = 0; hs_lo = 0; vs_lo = 0; mode_nz = 0; busy_cnt = 0; fs_cnt = 0;
    endtask

    // One clock: advance the reference raster, then sample outputs 1 time unit after the edge.
    task automatic tick();
        logic adv, hs_e, vs_e;
        @(posedge clk);
        adv = pix_ce_i && !rst;
        if (adv) begin
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        #1;
        cyc++;
        hs_e = !(mx >= HA + HF && mx < HA + HF + HS);
        vs_e = !(my >= VA + VF && my < VA + VF + VS);
        if (x_o !== 11'(mx) || y_o !== 11'(my)) xy_err++;
        if (hsync_o !== hs_e || vsync_o !== vs_e) sync_err++;
        if (frame_start_o !== (adv && mx == 0 && my == 0)) fs_err++;
        en_cnt   += int'(enable_o);
        hs_lo    += int'(!hsync_o);
        vs_lo    += int'(!vsync_o);
        mode_nz  += int'(mode_o != 2'd0);
        busy_cnt += int'(busy_o);
        fs_cnt   += int'(frame_start_o);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " x"}, 32'(x_o), 0);
        chk({tag, " y"}, 32'(y_o), 0);
        chk({tag, " mode"}, 32'(mode_o), 0);
        chk({tag, " enable"}, 32'(enable_o), 0);
        chk({tag, " hsync"}, 32'(hsync_o), 1);
        chk({tag, " vsync"}, 32'(vsync_o), 1);
        chk({tag, " ack"}, 32'(mode_ack_o), 0);
        chk({tag, " err"}, 32'(mode_err_o), 0);
        chk({tag, " frame_start"}, 32'(frame_start_o), 0);
        chk({tag, " busy"}, 32'(busy_o), 0);
    endtask

    task automatic to_origin(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(mx == 0 && my == 0) && n < 4 * FRAME);
        if (n >= 4 * FRAME) chk({tag, " timeout"}, 1, 0);
    endtask

    initial begin
        int n, c1, c2, ph;

        // Reset state
        tick(); tick();
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        pix_ce_i = 1'b1;

        // Free-running raster
        clr();
        repeat (FRAME) tick();
        chk("t1 frame_start after 1 frame", 32'(frame_start_o), 1);
        chk("t1 enable count", 32'(en_cnt), 32'(HA * VA));
        clr();
        repeat (FRAME) tick();
        chk("t1 frame_start count", 32'(fs_cnt), 1);
        chk("t1 enable count 2", 32'(en_cnt), 32'(HA * VA));
        chk("t1 hsync low cycles", 32'(hs_lo), 32'(HS * VT));
        chk("t1 vsync low cycles", 32'(vs_lo), 32'(VS * HT));
        chk("t1 busy cycles", 32'(busy_cnt), 0);

        // Mode commit at a frame boundary, then two dark frames
        repeat (HT) tick();
        mode_req_i = 1'b1; mode_sel_i = 2'd1;
        tick();
        chk("t2 ack", 32'(mode_ack_o), 1);
        chk("t2 err", 32'(mode_err_o), 0);
        chk("t2 busy", 32'(busy_o), 1);
        mode_req_i = 1'b0;
        clr();
        n = 0;
        while (n < 2 * FRAME) begin
            tick();
            n++;
            if (mx == 0 && my == 0) break;
            mode_nz += 0;
        end
        chk("t2 mode held before commit", 32'(mode_nz - int'(mode_o != 2'd0)), 0);
        chk("t2 mode at 0,0", 32'(mode_o), 1);
        chk("t2 enable at commit", 32'(enable_o), 0);
        clr();
        repeat (2 * FRAME - 1) tick();
        chk("t2 enable during blank", 32'(en_cnt), 0);
        chk("t2 busy during blank", 32'(busy_o), 1);
        tick();
        chk("t2 enable resumes", 32'(enable_o), 1);
        chk("t2 busy clear", 32'(busy_o), 0);
        clr();
        repeat (FRAME) tick();
        chk("t2 visible frame", 32'(en_cnt), 32'(HA * VA));

        // Illegal mode
        mode_req_i = 1'b1; mode_sel_i = 2'd3;
        tick();
        chk("t3 ack", 32'(mode_ack_o), 1);
        chk("t3 err", 32'(mode_err_o), 1);
        chk("t3 mode", 32'(mode_o), 1);
        chk("t3 busy", 32'(busy_o), 0);
        mode_req_i = 1'b0;
        tick();
        chk("t3 ack pulse", 32'(mode_ack_o), 0);
        chk("t3 err pulse", 32'(mode_err_o), 0);
        chk("t3 busy after", 32'(busy_o), 0);

        // Request held during BLANK is served only on return to RUN
        mode_req_i = 1'b1; mode_sel_i = 2'd0;
        tick();
        chk("t4 first ack", 32'(mode_ack_o), 1);
        mode_req_i = 1'b0;
        to_origin("t4 commit");
        chk("t4 mode 0", 32'(mode_o), 0);
        mode_req_i = 1'b1; mode_sel_i = 2'd2;
        n = 0;
        while (n < 3 * FRAME) begin
            tick();
            n++;
            if (mode_ack_o) break;
        end
        chk("t4 cycles to ack", 32'(n), 32'(2 * FRAME + 1));
        chk("t4 busy after ack", 32'(busy_o), 1);
        mode_req_i = 1'b0;
        to_origin("t4 commit2");
        chk("t4 mode 2", 32'(mode_o), 2);

        // Pixel enable at 1-of-4
        c1 = -1; c2 = -1; ph = 0;
        for (int i = 0; i < 12 * FRAME; i++) begin
            pix_ce_i = (ph == 0);
            ph = (ph + 1) % 4;
            tick();
            if (frame_start_o) begin
                if (c1 < 0) c1 = cyc;
                else begin
                    c2 = cyc;
                    break;
                end
            end
        end
        chk("t5 frame period", 32'(c2 - c1), 32'(4 * FRAME));
        pix_ce_i = 1'b1;

        // Reset while a commit is pending
        n = 0;
        while (busy_o && n < 4 * FRAME) begin
            tick();
            n++;
        end
        chk("t6 back in RUN", 32'(busy_o), 0);
        mode_req_i = 1'b1; mode_sel_i = 2'd1;
        tick();
        chk("t6 ack", 32'(mode_ack_o), 1);
        mode_req_i = 1'b0;
        n = 0;
        while (!(mx == 5 && my == 3) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        chk("t6 pending", 32'(busy_o), 1);
        rst = 1'b1;
        #1;
        mx = 0; my = 0;
        chk_reset_vals("t6 async reset");
        @(negedge clk);
        rst = 1'b0;
        clr();
        repeat (2 * FRAME) tick();
        chk("t6 mode never committed", 32'(mode_nz), 0);
        chk("t6 busy after reset", 32'(busy_cnt), 0);
        chk("t6 enable count", 32'(en_cnt), 32'(2 * HA * VA));

        // Whole-run raster, sync and frame_start agreement with the reference
        chk("raster x/y", 32'(xy_err), 0);
        chk("sync decode", 32'(sync_err), 0);
        chk("frame_start timing", 32'(fs_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
